// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mips_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUCTL_W = 3;
    localparam int unsigned SRCB_W   = 2;
    localparam int unsigned PCSRC_W  = 2;
    localparam int unsigned STATE_W  = 4;

    // Controller states; each instruction walks a subset of these.
    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } statetype_t;

    // Opcodes (instr[31:26]).
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
    localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0]).
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    // ALU operation codes.
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

    // ALU B operand select.
    localparam logic [SRCB_W-1:0] SRCB_RT    = 2'b00;
    localparam logic [SRCB_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SRCB_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SRCB_W-1:0] SRCB_IMMSH = 2'b11;

    // Next-PC select.
    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

    // True for any of the load opcodes.
    function automatic logic is_load_op(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// Combinational R-type funct to ALU control decoder with a validity flag.
module mc_aludec
    import mips_pkg::*;
(
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                funct_valid
);

    // Map supported functs; anything else is flagged invalid and falls back to add.
    always_comb begin
        alucontrol  = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore sequencing controller for the shared-memory MIPS datapath.
module mc_controller
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pcen,
    output logic                iord,
    output logic                irwrite,
    output logic                memwrite,
    output logic                regwrite,
    output logic                regdst,
    output logic                memtoreg,
    output logic                alusrca,
    output logic [SRCB_W-1:0]   alusrcb,
    output logic [PCSRC_W-1:0]  pcsrc,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                ne,
    output logic                half,
    output logic                b,
    output logic                illegal,
    output logic                instr_done
);

    statetype_t state;
    statetype_t state_next;

    logic                pcwrite;
    logic                branch;
    logic [ALUCTL_W-1:0] funct_alu;
    logic                funct_valid;
    logic                op_lh;
    logic                op_lb;

    mc_aludec u_aludec (
        .funct       (funct),
        .alucontrol  (funct_alu),
        .funct_valid (funct_valid)
    );

    assign op_lh = (op == OP_LH);
    assign op_lb = (op == OP_LB);

    // State register; reset drops straight back to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs from the current state and IR fields.
    always_comb begin
        state_next = state;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        pcsrc      = PCSRC_ALU;
        alucontrol = ALU_ADD;
        ne         = 1'b0;
        half       = 1'b0;
        b          = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;

        case (state)
            FETCH: begin
                iord    = 1'b0;
                alusrca = 1'b0;
                alusrcb = SRCB_FOUR;
                pcsrc   = PCSRC_ALU;
                if (mem_ready) begin
                    irwrite    = 1'b1;
                    pcwrite    = 1'b1;
                    state_next = DECODE;
                end
            end

            DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alusrca = 1'b0;
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_LH, OP_LB, OP_SW: state_next = MEMADR;
                    OP_RTYPE: begin
                        if (funct_valid) begin
                            state_next = RTYPEEX;
                        end else begin
                            illegal    = 1'b1;
                            state_next = FETCH;
                        end
                    end
                    OP_BEQ, OP_BNE: state_next = BRANCH;
                    OP_ADDI:        state_next = ADDIEX;
                    OP_J:           state_next = JUMP;
                    default: begin
                        illegal    = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end

            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                half    = op_lh;
                b       = op_lb;
                if (is_load_op(op)) begin
                    state_next = MEMRD;
                end else if (op == OP_SW) begin
                    state_next = MEMWR;
                end else begin
                    state_next = FETCH;
                end
            end

            MEMRD: begin
                iord = 1'b1;
                half = op_lh;
                b    = op_lb;
                if (mem_ready) begin
                    state_next = MEMWB;
                end
            end

            MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                regdst     = 1'b0;
                half       = op_lh;
                b          = op_lb;
                instr_done = 1'b1;
                state_next = FETCH;
            end

            MEMWR: begin
                // Write request stays up until memory accepts it.
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
            end

            RTYPEEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_RT;
                alucontrol = funct_alu;
                state_next = RTYPEWB;
            end

            RTYPEWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                memtoreg   = 1'b0;
                alucontrol = funct_alu;
                instr_done = 1'b1;
                state_next = FETCH;
            end

            BRANCH: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_RT;
                alucontrol = ALU_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
                ne         = (op == OP_BNE);
                instr_done = 1'b1;
                state_next = FETCH;
            end

            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                state_next = ADDIWB;
            end

            ADDIWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b0;
                instr_done = 1'b1;
                state_next = FETCH;
            end

            JUMP: begin
                pcsrc      = PCSRC_JUMP;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end

            default: begin
                state_next = FETCH;
            end
        endcase

        // Reset kills every write strobe and pulse immediately, even mid-instruction.
        if (!reset) begin
            pcwrite    = 1'b0;
            branch     = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end

        pcen = pcwrite | (branch & (zero ^ ne));
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected control words from an instruction-level model.
module tb_mc_controller;

    // Opcode / funct values of the supported instruction set.
    localparam logic [5:0] T_RT   = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_LH   = 6'b100001;
    localparam logic [5:0] T_LB   = 6'b100000;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       ne;
        logic       half;
        logic       b;
        logic       illegal;
        logic       instr_done;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       ne, half, b, illegal, instr_done;

    ctl_t  act;
    ctl_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;
    int    budget = 1000000;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .ne         (ne),
        .half       (half),
        .b          (b),
        .illegal    (illegal),
        .instr_done (instr_done)
    );

    assign act = {pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                  alusrcb, pcsrc, alucontrol, ne, half, b, illegal, instr_done};

    always #5 clk = ~clk;

    // Quiet control word: everything low, ALU adds.
    function automatic ctl_t dflt();
        ctl_t e;
        e = '0;
        e.alucontrol = 3'b010;
        return e;
    endfunction

    // FETCH addressing (PC, PC+4) without any write.
    function automatic ctl_t fetch_base();
        ctl_t e;
        e = dflt();
        e.alusrcb = 2'b01;
        return e;
    endfunction

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            F_SUB:   return 3'b110;
            F_AND:   return 3'b000;
            F_OR:    return 3'b001;
            F_SLT:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            T_RT:    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
            T_LW, T_LH, T_LB, T_SW, T_BEQ, T_BNE, T_ADDI, T_J: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic pick_zero(input int zm);
        if (zm == 2) return 1'($urandom);
        return (zm == 1);
    endfunction

    // Drive one cycle of inputs and queue the control word expected during it.
    task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic m, input ctl_t e, input string nm);
        if (budget == 0) return;
        budget--;
        reset     = r;
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = m;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // One whole instruction: fetch (with fst wait cycles), then its class-specific phases.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int fst, input int mst, input int zm);
        ctl_t e;
        logic z;
        bit   is_ld;
        for (int i = 0; i < fst; i++) begin
            cyc(1'b1, 6'($urandom), 6'($urandom), pick_zero(zm), 1'b0, fetch_base(), "fetch_wait");
        end
        e = fetch_base();
        e.irwrite = 1'b1;
        e.pcen    = 1'b1;
        cyc(1'b1, 6'($urandom), 6'($urandom), pick_zero(zm), 1'b1, e, "fetch");

        e = dflt();
        e.alusrcb = 2'b11;
        if (!ref_legal(o, f)) begin
            e.illegal = 1'b1;
            cyc(1'b1, o, f, pick_zero(zm), 1'($urandom), e, "decode_illegal");
            return;
        end
        cyc(1'b1, o, f, pick_zero(zm), 1'($urandom), e, "decode");

        is_ld = (o == T_LW) || (o == T_LH) || (o == T_LB);
        if (is_ld || o == T_SW) begin
            e = dflt();
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
            e.half    = (o == T_LH);
            e.b       = (o == T_LB);
            cyc(1'b1, o, f, pick_zero(zm), 1'($urandom), e, "memadr");
            if (is_ld) begin
                e = dflt();
                e.iord = 1'b1;
                e.half = (o == T_LH);
                e.b    = (o == T_LB);
                for (int i = 0; i < mst; i++) cyc(1'b1, o, f, pick_zero(zm), 1'b0, e, "memrd_wait");
                cyc(1'b1, o, f, pick_zero(zm), 1'b1, e, "memrd");
                e = dflt();
                e.regwrite   = 1'b1;
                e.memtoreg   = 1'b1;
                e.half       = (o == T_LH);
                e.b          = (o == T_LB);
                e.instr_done = 1'b1;
                cyc(1'b1, o, f, pick_zero(zm), 1'($urandom), e, "memwb");
            end else begin
                e = dflt();
                e.iord     = 1'b1;
                e.memwrite = 1'b1;
                for (int i = 0; i < mst; i++) cyc(1'b1, o, f, pick_zero(zm), 1'b0, e, "memwr_wait");
                e.instr_done = 1'b1;
                cyc(1'b1, o, f, pick_zero(zm), 1'b1, e, "memwr");
            end
        end else if (o == T_RT) begin
            e = dflt();
            e.alusrca    = 1'b1;
            e.alucontrol = ref_alu(f);
            cyc(1'b1, o, f, pick_zero(zm), 1'($urandom), e, "rtype_ex");
            e = dflt();
            e.regwrite   = 1'b1;
            e.regdst     = 1'b1;
            e.alucontrol = ref_alu(f);
            e.instr_done = 1'b1;
            cyc(1'b1, o, f, pick_zero(zm), 1'($urandom), e, "rtype_wb");
        end else if (o == T_BEQ || o == T_BNE) begin
            z = pick_zero(zm);
            e = dflt();
            e.alusrca    = 1'b1;
            e.alucontrol = 3'b110;
            e.pcsrc      = 2'b01;
            e.ne         = (o == T_BNE);
            e.pcen       = (o == T_BEQ) ? z : !z;
            e.instr_done = 1'b1;
            cyc(1'b1, o, f, z, 1'($urandom), e, "branch");
        end else if (o == T_ADDI) begin
            e = dflt();
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
            cyc(1'b1, o, f, pick_zero(zm), 1'($urandom), e, "addi_ex");
            e = dflt();
            e.regwrite   = 1'b1;
            e.instr_done = 1'b1;
            cyc(1'b1, o, f, pick_zero(zm), 1'($urandom), e, "addi_wb");
        end else begin
            e = dflt();
            e.pcsrc      = 2'b10;
            e.pcen       = 1'b1;
            e.instr_done = 1'b1;
            cyc(1'b1, o, f, pick_zero(zm), 1'($urandom), e, "jump");
        end
    endtask

    // Monitor: compare the live control word against the queued expectation every cycle.
    initial begin
        forever begin
            ctl_t  w;
            string n;
            @(negedge clk);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (act !== w) begin
                    failures++;
                    $display("FAIL %s t=%0t got=%05h want=%05h", n, $time, act, w);
                end
            end
        end
    end

    // Stimulus: reset, directed instructions, random program, mid-instruction reset.
    initial begin
        logic [5:0] ops[9];
        logic [5:0] o;
        logic [5:0] f;
        int         k;
        ops = '{T_RT, T_LW, T_LH, T_LB, T_SW, T_BEQ, T_BNE, T_ADDI, T_J};

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, fetch_base(), "reset_hold");

        run_instr(T_RT, F_ADD, 0, 0, 2);
        run_instr(T_LH, 6'd0, 0, 2, 2);
        run_instr(T_SW, 6'd0, 0, 3, 2);
        run_instr(T_BEQ, 6'd0, 0, 0, 1);
        run_instr(T_BNE, 6'd0, 0, 0, 1);
        run_instr(T_BEQ, 6'd0, 0, 0, 0);
        run_instr(T_BNE, 6'd0, 0, 0, 0);
        run_instr(T_J, 6'd0, 0, 0, 2);
        run_instr(6'b111111, 6'd0, 0, 0, 2);
        run_instr(T_RT, 6'b000111, 0, 0, 2);
        run_instr(T_LW, 6'd0, 2, 0, 2);
        run_instr(T_LB, 6'd0, 0, 1, 2);
        run_instr(T_ADDI, 6'd0, 0, 0, 2);
        run_instr(T_RT, F_SUB, 0, 0, 2);
        run_instr(T_RT, F_AND, 1, 0, 2);
        run_instr(T_RT, F_OR, 0, 0, 2);
        run_instr(T_RT, F_SLT, 0, 0, 2);

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 11);
            f = 6'($urandom);
            if (k < 9) begin
                o = ops[k];
                if (o == T_RT) begin
                    case ($urandom_range(0, 4))
                        0: f = F_ADD;
                        1: f = F_SUB;
                        2: f = F_AND;
                        3: f = F_OR;
                        default: f = F_SLT;
                    endcase
                end
            end else if (k == 9) begin
                do o = 6'($urandom); while (ref_legal(o, 6'd0));
            end else begin
                o = T_RT;
            end
            run_instr(o, f,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0, 2);
        end

        // Abort a store while its write request is pending.
        budget = 4;
        run_instr(T_SW, 6'd0, 0, 3, 2);
        budget = 1000000;
        cyc(1'b0, T_SW, 6'd0, 1'b1, 1'b1, fetch_base(), "reset_abort");
        cyc(1'b0, T_SW, 6'd0, 1'b0, 1'b1, fetch_base(), "reset_abort_hold");
        run_instr(T_RT, F_ADD, 0, 0, 2);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle sequencing controller for the MIPS core with shared memory. It replaces the single-cycle decoder when instruction fetch and data access use one memory port. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives the multicycle datapath's enables and muxes, and stalls on a memory ready handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; state forced to FETCH while low
- op  in  6  instr[31:26] from the datapath instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- pcen  out  1  PC load = pcwrite | (branch & (zero ^ ne))
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write request
- regwrite  out  1  register file write
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  writeback source: 0 = ALUOut, 1 = load data
- alusrca  out  1  ALU A: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B: 00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- ne  out  1  branch-on-not-equal
- half  out  1  halfword load (lh)
- b  out  1  byte load (lb)
- illegal  out  1  one-cycle pulse on an unsupported op or funct
- instr_done  out  1  one-cycle pulse in the final state of each instruction

## Operation
- Opcodes:
  - R-type 000000
  - lw 100011
  - lh 100001
  - lb 100000
  - sw 101011
  - beq 000100
  - bne 000101
  - addi 001000
  - j 000010
- R-type functs:
  - add 100000
  - sub 100010
  - and 100100
  - or 100101
  - slt 101010
- Output defaults: every output is 0 except alucontrol, which defaults to 010. pcen is always computed from the pcwrite and branch terms.
- States and their outputs:
  - FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00.
    - While mem_ready=0: stay in FETCH, no writes.
    - When mem_ready=1: irwrite=1, pcwrite=1, go to DECODE.
  - DECODE: alusrca=0, alusrcb=11 (precomputes the branch target).
    - Next state: lw/lh/lb/sw → MEMADR; R-type with known funct → RTYPEEX; beq/bne → BRANCH; addi → ADDIEX; j → JUMP.
    - Otherwise: illegal=1, go to FETCH.
  - MEMADR: alusrca=1, alusrcb=10. Loads go to MEMRD, sw goes to MEMWR.
  - MEMRD: iord=1. Hold until mem_ready=1, then go to MEMWB.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0. half=1 for lh, b=1 for lb. Then FETCH.
  - MEMWR: iord=1, memwrite=1, held every cycle until mem_ready=1. Then FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct. Then RTYPEWB.
  - RTYPEWB: regwrite=1, regdst=1, memtoreg=0, alucontrol from funct. Then FETCH.
  - BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1, ne=1 for bne. Then FETCH.
  - ADDIEX: alusrca=1, alusrcb=10. Then ADDIWB.
  - ADDIWB: regwrite=1, regdst=0. Then FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Then FETCH.
- half and b are also asserted in MEMADR and MEMRD for lh and lb, so memory lane selection is stable during the access.
- instr_done is asserted in MEMWB, RTYPEWB, ADDIWB, BRANCH and JUMP, and in MEMWR on its mem_ready cycle.
- Outputs are purely a function of state, op, funct, zero and mem_ready. The controller stores no opcode; the instruction register holds it.

## Timing
- Reset:
  - While reset is low: state is FETCH; pcen, irwrite, memwrite, regwrite, illegal and instr_done are forced to 0.
  - Remaining outputs take their FETCH values (alusrcb=01, pcsrc=00, alucontrol=010).
  - First fetch happens on the first rising edge after reset deasserts, provided mem_ready=1.
- Latency with zero wait states (mem_ready held high):
  - lw/lh/lb: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq/bne, j: 3 cycles
  - unsupported op: 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. No other state samples mem_ready.
- Reset asserted mid-instruction aborts it immediately. Any in-flight memwrite or regwrite drops asynchronously.
- Branch resolution: pcen in BRANCH is combinational on zero in the same cycle.
  - beq taken when zero=1.
  - bne taken when zero=0.

## Structure
- mips_pkg holds:
  - the state enum (statetype_t)
  - opcode and funct localparams
  - alucontrol codes
  - alusrcb and pcsrc encodings
- The sub-module mc_aludec is a combinational funct → alucontrol decoder. It also outputs a funct_valid bit, which DECODE uses for the illegal check.
- Main FSM: a single always_ff for the state register and a single always_comb for next-state and outputs.

## Test plan
- Reset held low 3 cycles with mem_ready=1: pcen=irwrite=memwrite=regwrite=0; after release, pcen=1 and irwrite=1 on the first edge.
- add (op 000000, funct 100000), mem_ready=1: states FETCH→DECODE→RTYPEEX→RTYPEWB; alucontrol=010 in RTYPEEX; regwrite=1, regdst=1 only in RTYPEWB; instr_done pulses cycle 4.
- lh (op 100001) with mem_ready=0 for 2 cycles in MEMRD: 7 cycles total; half=1 from MEMADR through MEMWB; regwrite=1 with memtoreg=1 once.
- sw with mem_ready low 3 cycles: memwrite=1 for 4 consecutive cycles; instr_done pulses only on the ready cycle.
- beq with zero=1 → pcen=1, pcsrc=01; bne with zero=1 → pcen=0; j → pcen=1, pcsrc=10 in cycle 3.
- op 111111: illegal pulses in DECODE and the FSM returns to FETCH. R-type with funct 000111: illegal pulses and regwrite never asserts.
